// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the act_pipe activation unit.
// Holds the activation mode encodings, the mode type and the
// configuration FSM state type.
package act_pkg;

    localparam logic [1:0] ACT_BYPASS = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_CLIP   = 2'd2;
    localparam logic [1:0] ACT_LEAKY  = 2'd3;

    typedef logic [1:0] act_mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } act_state_t;

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational arithmetic for one activation lane.
// The stage-1 half (x, clip, shift -> neg, over, shr) feeds the stage-1
// registers in act_pipe; the stage-2 half (s1_* -> y) selects the final
// result from those registered values.
// Ports:
//   x, clip, shift   stage-1 inputs (clip is already floored at 0)
//   neg, over, shr   stage-1 precomputed sign, clip compare, shifted value
//   s1_mode, s1_x, s1_clip, s1_neg, s1_over, s1_shr  registered stage-1 values
//   y                selected lane output
module act_lane
    import act_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SHW = 5
) (
    input  logic signed [DW-1:0]  x,
    input  logic signed [DW-1:0]  clip,
    input  logic [SHW-1:0]        shift,
    output logic                  neg,
    output logic                  over,
    output logic signed [DW-1:0]  shr,
    input  act_mode_t             s1_mode,
    input  logic signed [DW-1:0]  s1_x,
    input  logic signed [DW-1:0]  s1_clip,
    input  logic                  s1_neg,
    input  logic                  s1_over,
    input  logic signed [DW-1:0]  s1_shr,
    output logic signed [DW-1:0]  y
);

    assign neg  = x[DW-1];
    assign over = (x > clip);

    // Guard the shift amount against DW so an oversized shift is defined:
    // it saturates to the sign fill.
    always_comb begin
        if (32'(shift) >= DW) begin
            shr = {DW{x[DW-1]}};
        end else begin
            shr = x >>> shift;
        end
    end

    always_comb begin
        y = s1_x;
        case (s1_mode)
            ACT_RELU: begin
                if (s1_neg) y = '0;
            end
            ACT_CLIP: begin
                if (s1_neg)       y = '0;
                else if (s1_over) y = s1_clip;
            end
            ACT_LEAKY: begin
                if (s1_neg) y = s1_shr;
            end
            default: y = s1_x;
        endcase
    end

endmodule

// File: rtl/act_pipe.sv
// act_pipe: multi-lane 2-stage valid/ready activation pipeline.
// Config (cfg_mode/cfg_clip/cfg_shift) is captured on the first beat of a
// frame and held until that frame's last beat is accepted.
// Ports:
//   clk, rst (async, active-high)
//   cfg_mode, cfg_clip, cfg_shift  activation configuration
//   in_valid/in_ready/in_data/in_last     input stream
//   out_valid/out_ready/out_data/out_last output stream
//   busy   frame active or a pipeline stage occupied
// Optional macro ACT_ZCNT_EN adds zcnt/zcnt_vld: per-frame count of zero
// output lanes, saturating, published with a 1-cycle pulse on the last beat.
module act_pipe
    import act_pkg::*;
#(
    parameter int LANES = 7,
    parameter int DW    = 32,
    parameter int SHW   = 5,
    parameter int ZCW   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic [DW-1:0]         cfg_clip,
    input  logic [SHW-1:0]        cfg_shift,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy
`ifdef ACT_ZCNT_EN
    ,
    output logic [ZCW-1:0]        zcnt,
    output logic [0:0]            zcnt_vld
`endif
);

    act_state_t            state_reg;
    act_mode_t             mode_sh_reg;
    logic [DW-1:0]         clip_sh_reg;
    logic [SHW-1:0]        shift_sh_reg;

    logic                  s1_valid_reg;
    logic                  s1_last_reg;
    act_mode_t             s1_mode_reg;
    logic [DW-1:0]         s1_clip_reg;
    logic [LANES*DW-1:0]   s1_x_reg;
    logic [LANES-1:0]      s1_neg_reg;
    logic [LANES-1:0]      s1_over_reg;
    logic [LANES*DW-1:0]   s1_shr_reg;

    logic                  ready1;
    logic                  ready2;
    logic                  accept;
    act_mode_t             cur_mode;
    logic [DW-1:0]         cur_clip;
    logic [DW-1:0]         clip_eff;
    logic [SHW-1:0]        cur_shift;
    logic [LANES-1:0]      lane_neg;
    logic [LANES-1:0]      lane_over;
    logic [LANES*DW-1:0]   lane_shr;
    logic [LANES*DW-1:0]   lane_y;

    assign ready2   = !out_valid || out_ready;
    assign ready1   = !s1_valid_reg || ready2;
    assign in_ready = ready1;
    assign accept   = in_valid && ready1;
    assign busy     = (state_reg == ST_ACTIVE) || s1_valid_reg || out_valid;

    // In IDLE the accepted beat is the first of a frame, so it uses the live
    // cfg inputs (the same values being latched into the shadows).
    assign cur_mode  = (state_reg == ST_IDLE) ? cfg_mode  : mode_sh_reg;
    assign cur_clip  = (state_reg == ST_IDLE) ? cfg_clip  : clip_sh_reg;
    assign cur_shift = (state_reg == ST_IDLE) ? cfg_shift : shift_sh_reg;
    // A negative clip bound behaves as 0.
    assign clip_eff  = cur_clip[DW-1] ? '0 : cur_clip;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            act_lane #(.DW(DW), .SHW(SHW)) u_lane (
                .x       (in_data[gi*DW +: DW]),
                .clip    (clip_eff),
                .shift   (cur_shift),
                .neg     (lane_neg[gi]),
                .over    (lane_over[gi]),
                .shr     (lane_shr[gi*DW +: DW]),
                .s1_mode (s1_mode_reg),
                .s1_x    (s1_x_reg[gi*DW +: DW]),
                .s1_clip (s1_clip_reg),
                .s1_neg  (s1_neg_reg[gi]),
                .s1_over (s1_over_reg[gi]),
                .s1_shr  (s1_shr_reg[gi*DW +: DW]),
                .y       (lane_y[gi*DW +: DW])
            );
        end
    endgenerate

    // Configuration FSM with shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            mode_sh_reg  <= ACT_BYPASS;
            clip_sh_reg  <= '0;
            shift_sh_reg <= '0;
        end else if (accept) begin
            if (state_reg == ST_IDLE) begin
                mode_sh_reg  <= cfg_mode;
                clip_sh_reg  <= cfg_clip;
                shift_sh_reg <= cfg_shift;
                state_reg    <= in_last ? ST_IDLE : ST_ACTIVE;
            end else if (in_last) begin
                state_reg    <= ST_IDLE;
            end
        end
    end

    // Two pipeline stages; each loads only when its downstream can take it,
    // so data and valid hold stable across a stall. Mode and clip travel
    // with the beat so a new frame's config cannot corrupt older beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_mode_reg  <= ACT_BYPASS;
            s1_clip_reg  <= '0;
            s1_x_reg     <= '0;
            s1_neg_reg   <= '0;
            s1_over_reg  <= '0;
            s1_shr_reg   <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
        end else begin
            if (ready1) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_last_reg <= in_last;
                    s1_mode_reg <= cur_mode;
                    s1_clip_reg <= clip_eff;
                    s1_x_reg    <= in_data;
                    s1_neg_reg  <= lane_neg;
                    s1_over_reg <= lane_over;
                    s1_shr_reg  <= lane_shr;
                end
            end
            if (ready2) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data <= lane_y;
                    out_last <= s1_last_reg;
                end
            end
        end
    end

`ifdef ACT_ZCNT_EN
    localparam int PCW = $clog2(LANES + 1);

    logic [LANES-1:0]  zero_flag;
    logic [PCW-1:0]    zpop;
    logic [ZCW:0]      zsum;
    logic [ZCW-1:0]    zacc_reg;
    logic [ZCW-1:0]    zacc_next;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_zero
            assign zero_flag[gi] = (out_data[gi*DW +: DW] == '0);
        end
    endgenerate

    always_comb begin
        zpop = '0;
        for (int i = 0; i < LANES; i++) begin
            zpop = zpop + PCW'(zero_flag[i]);
        end
    end

    // One extra bit catches the carry used for saturation.
    assign zsum      = {1'b0, zacc_reg} + (ZCW + 1)'(zpop);
    assign zacc_next = zsum[ZCW] ? '1 : zsum[ZCW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc_reg <= '0;
            zcnt     <= '0;
            zcnt_vld <= '0;
        end else begin
            zcnt_vld <= '0;
            if (out_valid && out_ready) begin
                zcnt     <= zacc_next;
                zacc_reg <= out_last ? '0 : zacc_next;
                zcnt_vld <= out_last;
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_pipe.sv
module tb_act_pipe;

    localparam int LANES = 7;
    localparam int DW    = 32;
    localparam int SHW   = 5;
    localparam int W     = LANES * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     cfg_mode = '0;
    logic [DW-1:0]  cfg_clip = '0;
    logic [SHW-1:0] cfg_shift = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;

    act_pipe #(.LANES(LANES), .DW(DW), .SHW(SHW), .ZCW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_clip  (cfg_clip),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           c;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            rdy_mode = 0;    // 0 always, 1 pattern 1,0,0,1, 2 random, 3 never
    bit            lat_chk  = 0;
    bit            in_frame = 0;
    int            fr_mode, fr_clip, fr_shift;
    bit            stall_prev = 0;
    logic [W-1:0]  stall_data;
    logic          stall_last;
    bit            got_seen;
    logic [W-1:0]  got_data;
    logic          got_last;
    int            kat_in[LANES];
    int            kat_exp[LANES];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference activation in plain integer arithmetic; leaky is a floor
    // division by 2**shift.
    function automatic int act_ref(input int x, input int mode, input int clip, input int sh);
        longint lx, c, p, qq, r;
        lx = x;
        case (mode)
            0: r = lx;
            1: r = (lx < 0) ? 0 : lx;
            2: begin
                c = (clip < 0) ? 0 : clip;
                r = (lx < 0) ? 0 : ((lx > c) ? c : lx);
            end
            default: begin
                if (lx >= 0) r = lx;
                else begin
                    p  = longint'(1) << sh;
                    qq = lx / p;
                    if (qq * p != lx) qq = qq - 1;
                    r = qq;
                end
            end
        endcase
        return int'(r);
    endfunction

    function automatic logic next_rdy();
        case (rdy_mode)
            0: return 1'b1;
            1: return (cyc % 4 == 0) || (cyc % 4 == 3);
            2: return ($urandom_range(0, 3) != 0);
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // update the model with this cycle's handshakes.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic il,
                        input logic ordy, output logic acc);
        exp_t e, ne;
        logic [W-1:0] ed;
        in_valid = iv; in_data = id; in_last = il; out_ready = ordy;
        #1;
        check("in_ready", W'(in_ready), W'(!(q.size() >= 2 && !ordy)));
        check("busy", W'(busy), W'(q.size() != 0 || in_frame));
        if (stall_prev) begin
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_data", out_data, stall_data);
            check("stall_last", W'(out_last), W'(stall_last));
        end
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("extra_beat", W'(out_valid), W'(0));
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.d);
                check("out_last", W'(out_last), W'(e.l));
                if (lat_chk) check("latency", W'(cyc - e.c), W'(2));
                got_seen = 1; got_data = out_data; got_last = out_last;
            end
        end
        stall_prev = out_valid && !ordy;
        stall_data = out_data;
        stall_last = out_last;
        acc = iv && in_ready;
        if (acc) begin
            if (!in_frame) begin
                fr_mode = int'(cfg_mode); fr_clip = int'(cfg_clip); fr_shift = int'(cfg_shift);
            end
            in_frame = !il;
            for (int i = 0; i < LANES; i++)
                ed[i*DW +: DW] = act_ref(int'(id[i*DW +: DW]), fr_mode, fr_clip, fr_shift);
            ne.d = ed; ne.l = il; ne.c = cyc;
            q.push_back(ne);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, '0, 1'b0, next_rdy(), acc);
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        logic acc;
        int n;
        n = 0;
        do begin
            step(1'b1, d, l, next_rdy(), acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check("accept_timeout", W'(acc), W'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            idle();
            n++;
        end
        check("drain_empty", W'(q.size()), W'(0));
        idle();
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 5))
                0: d[i*DW +: DW] = 32'd0;
                1: d[i*DW +: DW] = 32'hFFFF_FFFF;
                2: d[i*DW +: DW] = 32'h7FFF_FFFF;
                3: d[i*DW +: DW] = 32'h8000_0000;
                4: d[i*DW +: DW] = 32'($urandom_range(0, 400)) - 32'd200;
                default: d[i*DW +: DW] = $urandom;
            endcase
        end
        return d;
    endfunction

    // Single-beat known-answer test against hand-computed lanes.
    task automatic kat(input string tag, input int m, input int c, input int s);
        logic [W-1:0] d, ex;
        for (int i = 0; i < LANES; i++) begin
            d[i*DW +: DW]  = kat_in[i];
            ex[i*DW +: DW] = kat_exp[i];
        end
        cfg_mode = 2'(m); cfg_clip = c; cfg_shift = SHW'(s);
        rdy_mode = 0; lat_chk = 1; got_seen = 0;
        send_beat(d, 1'b1);
        repeat (3) idle();
        check({tag, "_seen"}, W'(got_seen), W'(1));
        check({tag, "_data"}, got_data, ex);
        check({tag, "_last"}, W'(got_last), W'(1));
        lat_chk = 0;
    endtask

    initial begin
        int len;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_busy", W'(busy), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", W'(in_ready), W'(1));

        // Known answers
        kat_in  = '{5, -3, 0, 32'h7FFF_FFFF, 32'h8000_0000, -1, 1};
        kat_exp = '{5, 0, 0, 32'h7FFF_FFFF, 0, 0, 1};
        kat("relu", 1, 0, 0);
        kat_in  = '{150, 100, -20, 99, 0, 0, 0};
        kat_exp = '{100, 100, 0, 99, 0, 0, 0};
        kat("clip100", 2, 100, 0);
        kat_exp = '{0, 0, 0, 0, 0, 0, 0};
        kat("clipneg", 2, -5, 0);
        kat_in  = '{-17, 8, 0, 0, 0, 0, 0};
        kat_exp = '{-5, 8, 0, 0, 0, 0, 0};
        kat("leaky2", 3, 0, 2);
        kat_in  = '{-1, -17, 5, 0, 0, 0, 0};
        kat_exp = '{-1, -1, 5, 0, 0, 0, 0};
        kat("leaky31", 3, 0, 31);
        kat_in  = '{-17, 8, 0, 0, 0, 0, 0};
        kat_exp = '{-17, 8, 0, 0, 0, 0, 0};
        kat("leaky0", 3, 0, 0);

        // Backpressure: 10-beat frame with out_ready pattern 1,0,0,1
        rdy_mode = 1; cfg_mode = 2'd1;
        for (int b = 0; b < 10; b++) send_beat(rand_beat(), b == 9);
        drain();

        // Config lock: frame A ReLU with cfg switched mid-frame, then
        // back-to-back frame B in bypass
        rdy_mode = 0; cfg_mode = 2'd1;
        for (int b = 0; b < 5; b++) begin
            send_beat(rand_beat(), b == 4);
            cfg_mode = 2'd0;
        end
        for (int b = 0; b < 4; b++) begin
            send_beat(rand_beat(), b == 3);
            cfg_mode = 2'd3; cfg_shift = 5'd4;
        end
        drain();

        // Reset mid-frame drops in-flight beats
        rdy_mode = 3; cfg_mode = 2'd1;
        send_beat(rand_beat(), 1'b0);
        send_beat(rand_beat(), 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); in_frame = 0; stall_prev = 0;
        @(posedge clk); #1;
        rdy_mode = 0; cfg_mode = 2'd3; cfg_shift = 5'd1;
        for (int b = 0; b < 3; b++) send_beat(rand_beat(), b == 2);
        drain();

        // Randomized frames with random cfg churn and backpressure
        for (int f = 0; f < 30; f++) begin
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_clip  = ($urandom_range(0, 3) == 0) ? -32'($urandom_range(1, 50))
                                                    : 32'($urandom_range(0, 1000));
            cfg_shift = SHW'($urandom_range(0, 31));
            rdy_mode  = $urandom_range(0, 2);
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle();
                send_beat(rand_beat(), b == len - 1);
                cfg_mode  = 2'($urandom_range(0, 3));
                cfg_clip  = $urandom;
                cfg_shift = SHW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 2) == 0) drain();
        end
        rdy_mode = 2;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
